// File: rtl/mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic two;
    } booth_code_t;

    // Number of radix-4 digits for a WIDTH-bit operand extended by two bits.
    function automatic int unsigned num_digits(input int unsigned width);
        return width / 2 + 1;
    endfunction

    function automatic booth_code_t booth_encode(input logic [2:0] win);
        booth_code_t code;
        code.zero = (win == 3'b000) || (win == 3'b111);
        code.neg  = win[2];
        code.two  = (win == 3'b011) || (win == 3'b100);
        return code;
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// One radix-4 Booth digit: maps a 3-bit multiplier window to a signed
// partial product of 0, +/-M or +/-2M.
module booth_r4_digit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic [2:0]       i_window,
    input  logic [WIDTH+1:0] i_mcand,
    output logic [WIDTH+3:0] o_pp
);

    localparam int unsigned PP_W = WIDTH + 4;

    booth_code_t     w_code;
    logic [PP_W-1:0] w_mag;

    always_comb begin
        w_code = booth_encode(i_window);
        w_mag  = {{2{i_mcand[WIDTH+1]}}, i_mcand};
        if (w_code.two) begin
            w_mag = w_mag << 1;
        end
        o_pp = '0;
        if (!w_code.zero) begin
            o_pp = w_code.neg ? (~w_mag + PP_W'(1)) : w_mag;
        end
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per transaction,
// retiring DIGITS_PER_CYCLE digits per BUSY cycle with valid/ready on both sides.
module booth_r4_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH            = 128,
    parameter int unsigned DIGITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   ab,
    output logic                 busy
);

    localparam int unsigned D     = num_digits(WIDTH);
    localparam int unsigned K     = DIGITS_PER_CYCLE;
    localparam int unsigned EXT_W = WIDTH + 2;
    localparam int unsigned QX_W  = WIDTH + 3;
    localparam int unsigned PP_W  = WIDTH + 4;
    localparam int unsigned ACC_W = 2 * WIDTH + 4;
    localparam int unsigned CNT_W = $clog2(D + 1);

    if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("booth_r4_multiplier: WIDTH must be even and at least 4");
    end
    if ((K == 0) || ((D % K) != 0)) begin : g_bad_k
        $error("booth_r4_multiplier: DIGITS_PER_CYCLE must divide WIDTH/2+1");
    end

    mul_state_t         r_state;
    mul_state_t         w_state_nxt;
    logic [EXT_W-1:0]   r_mcand;
    logic [QX_W-1:0]    r_qx;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_ab;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;
    logic [EXT_W-1:0]   w_ext_a;
    logic [EXT_W-1:0]   w_ext_b;
    logic               w_last;
    logic [PP_W-1:0]    w_pp [K];
    logic [ACC_W-1:0]   w_acc_nxt;

    assign w_ext_a = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign w_ext_b = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    assign w_last  = (r_cnt == CNT_W'(D - K));

    // r_qx shifts right each cycle, so the current digits always sit at the bottom.
    for (genvar gk = 0; gk < K; gk++) begin : g_digit
        booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
            .i_window (r_qx[2*gk +: 3]),
            .i_mcand  (r_mcand),
            .o_pp     (w_pp[gk])
        );
    end

    always_comb begin
        w_acc_nxt = r_acc;
        for (int j = 0; j < int'(K); j++) begin
            w_acc_nxt = w_acc_nxt
                      + (ACC_W'($signed(w_pp[j])) << (2 * (int'(r_cnt) + j)));
        end
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = BUSY;
            BUSY:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        unique case (w_state_nxt)
            IDLE:    w_in_ready_nxt  = 1'b1;
            BUSY:    w_busy_nxt      = 1'b1;
            DONE: begin
                w_out_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            default: w_in_ready_nxt  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand <= '0;
            r_qx    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ab    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand <= w_ext_a;
                        r_qx    <= {w_ext_b, 1'b0};
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                BUSY: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + CNT_W'(K);
                    r_qx  <= r_qx >> (2 * K);
                    if (w_last) begin
                        r_ab <= w_acc_nxt[2*WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign ab        = r_ab;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Directed bench for the radix-4 Booth multiplier at WIDTH=8 (K=1 and K=5).
module tb_booth_r4_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, iv1, ir1, sg1, ov1, or1, bz1;
    logic [7:0]  a1, b1;
    logic [15:0] ab1;
    logic        rst2, iv2, ir2, sg2, ov2, or2, bz2;
    logic [7:0]  a2, b2;
    logic [15:0] ab2;

    booth_r4_multiplier #(.WIDTH(8), .DIGITS_PER_CYCLE(1)) u_k1 (
        .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .is_signed(sg1), .out_valid(ov1), .out_ready(or1), .ab(ab1), .busy(bz1)
    );

    booth_r4_multiplier #(.WIDTH(8), .DIGITS_PER_CYCLE(5)) u_k5 (
        .clk(clk), .reset(rst2), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .is_signed(sg2), .out_valid(ov2), .out_ready(or2), .ab(ab2), .busy(bz2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One K=1 transaction with out_ready held high; checks latency and product.
    task automatic op1(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic s, input logic [15:0] exp);
        int n;
        a1 = x; b1 = y; sg1 = s; iv1 = 1'b1; or1 = 1'b1;
        tick();
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd5);
        check({tag, "_ab"}, 32'(ab1), 32'(exp));
        tick();
    endtask

    logic [7:0]  sa [8];
    logic [7:0]  sb [8];
    logic        ss [8];
    logic [15:0] se [8];

    initial begin
        int bad, n, acc_n, res_n, last_acc;
        logic acc_now;
        logic [7:0] x, y;
        logic s;
        logic signed [15:0] sx, sy;
        logic [15:0] exp16;

        sa = '{8'h12, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'hFE, 8'h0A, 8'hC0};
        sb = '{8'h34, 8'h01, 8'h02, 8'h7F, 8'h7F, 8'h03, 8'h0B, 8'hC0};
        ss = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        se = '{16'h03A8, 16'hFFFF, 16'h0100, 16'h3F01, 16'h3F80, 16'hFFFA, 16'h006E, 16'h1000};

        rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; sg1 = 1'b0;
        rst2 = 1'b1; iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0; sg2 = 1'b0;
        tick();
        tick();
        rst1 = 1'b0;
        rst2 = 1'b0;
        check("rst_in_ready", 32'(ir1), 32'd1);
        check("rst_out_valid", 32'(ov1), 32'd0);
        check("rst_busy", 32'(bz1), 32'd0);
        check("rst_ab", 32'(ab1), 32'd0);

        // Unsigned maximum with a cycle-by-cycle view of the BUSY window.
        a1 = 8'hFF; b1 = 8'hFF; sg1 = 1'b0; iv1 = 1'b1; or1 = 1'b1;
        tick();
        iv1 = 1'b0;
        bad = 0;
        for (int c = 1; c <= 5; c++) begin
            if (ov1 !== 1'b0 || ir1 !== 1'b0 || bz1 !== 1'b1) bad++;
            tick();
        end
        check("umax_busy_window", 32'(bad), 32'd0);
        check("umax_out_valid_c6", 32'(ov1), 32'd1);
        check("umax_in_ready_c6", 32'(ir1), 32'd0);
        check("umax_ab", 32'(ab1), 32'h0000FE01);
        tick();
        check("umax_back_idle", 32'({ir1, ov1, bz1}), 32'b100);
        check("umax_ab_hold", 32'(ab1), 32'h0000FE01);

        op1("s_m128_m128", 8'h80, 8'h80, 1'b1, 16'h4000);
        op1("s_m128_p127", 8'h80, 8'h7F, 1'b1, 16'hC080);
        op1("s_zero_m1",   8'h00, 8'hFF, 1'b1, 16'h0000);
        op1("s_m1_m1",     8'hFF, 8'hFF, 1'b1, 16'h0001);
        op1("u_m1_m1",     8'hFF, 8'h01, 1'b0, 16'h00FF);

        // Backpressure: DONE must hold while new operands are offered.
        or1 = 1'b0; a1 = 8'h03; b1 = 8'h05; sg1 = 1'b0; iv1 = 1'b1;
        tick();
        iv1 = 1'b0;
        n = 0;
        while (!ov1 && n < 20) begin
            tick();
            n++;
        end
        check("bp_out_valid", 32'(ov1), 32'd1);
        for (int i = 0; i < 10; i++) begin
            iv1 = i[0];
            a1 = 8'h77; b1 = 8'h11;
            check("bp_hold", 32'({ov1, bz1, ir1, ab1}), 32'({1'b1, 1'b1, 1'b0, 16'h000F}));
            tick();
        end
        iv1 = 1'b0;
        or1 = 1'b1;
        tick();
        check("bp_release", 32'({ir1, ov1, bz1}), 32'b100);
        check("bp_ab_hold", 32'(ab1), 32'h0000000F);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (ov1 !== 1'b0 || bz1 !== 1'b0) bad++;
            tick();
        end
        check("bp_no_second_op", 32'(bad), 32'd0);

        // Reset in the second BUSY cycle.
        a1 = 8'h09; b1 = 8'h09; sg1 = 1'b0; iv1 = 1'b1; or1 = 1'b1;
        tick();
        iv1 = 1'b0;
        tick();
        check("mid_busy", 32'(bz1), 32'd1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        check("mid_rst_state", 32'({ir1, ov1, bz1}), 32'b100);
        check("mid_rst_ab", 32'(ab1), 32'd0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (ov1 !== 1'b0) bad++;
            tick();
        end
        check("mid_rst_no_valid", 32'(bad), 32'd0);
        op1("post_rst", 8'h09, 8'h09, 1'b0, 16'h0051);

        // Streaming with both handshakes held high.
        acc_n = 0; res_n = 0; last_acc = 0;
        a1 = sa[0]; b1 = sb[0]; sg1 = ss[0]; iv1 = 1'b1; or1 = 1'b1;
        for (int cyc = 0; cyc < 100 && res_n < 8; cyc++) begin
            acc_now = ir1 & iv1;
            tick();
            if (acc_now) begin
                if (acc_n > 0) check("stream_gap", 32'(cyc - last_acc), 32'd7);
                last_acc = cyc;
                acc_n++;
                if (acc_n < 8) begin
                    a1 = sa[acc_n]; b1 = sb[acc_n]; sg1 = ss[acc_n];
                end else begin
                    iv1 = 1'b0;
                end
            end
            if (ov1 && res_n < 8) begin
                check("stream_ab", 32'(ab1), 32'(se[res_n]));
                res_n++;
            end
        end
        iv1 = 1'b0;
        check("stream_count", 32'(res_n), 32'd8);

        // K=5: one BUSY cycle, random operands and random consumer stalls.
        for (int i = 0; i < 200; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            if (i == 0) begin x = 8'h80; y = 8'h80; s = 1'b1; end
            if (i == 1) begin x = 8'hFF; y = 8'hFF; s = 1'b0; end
            if (s) begin
                sx = $signed(x);
                sy = $signed(y);
                exp16 = 16'(sx * sy);
            end else begin
                exp16 = 16'(16'(x) * 16'(y));
            end
            a2 = x; b2 = y; sg2 = s; iv2 = 1'b1;
            or2 = 1'($urandom_range(0, 1));
            tick();
            iv2 = 1'b0;
            check("k5_lat_busy", 32'(ov2), 32'd0);
            tick();
            check("k5_lat_done", 32'(ov2), 32'd1);
            check("k5_ab", 32'(ab2), 32'(exp16));
            n = 0;
            or2 = 1'($urandom_range(0, 1));
            while (!or2 && n < 50) begin
                tick();
                n++;
                or2 = 1'($urandom_range(0, 1));
            end
            tick();
            check("k5_idle", 32'(ir2), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
